// File: rtl/axi_sram_slave.sv
// AXI4 slave terminating a 64-bit master on a single-port synchronous SRAM.
// One outstanding transaction; reads and writes arbitrated round-robin.
module axi_sram_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] MEM_BYTES = 32'h0800_0000,
  parameter int          WORD_AW   = 24
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         s_awid,
  input  logic [31:0]        s_awaddr,
  input  logic [7:0]         s_awlen,
  input  logic [2:0]         s_awsize,
  input  logic [1:0]         s_awburst,
  input  logic               s_awvalid,
  output logic               s_awready,
  input  logic [63:0]        s_wdata,
  input  logic [7:0]         s_wstrb,
  input  logic               s_wlast,
  input  logic               s_wvalid,
  output logic               s_wready,
  output logic [3:0]         s_bid,
  output logic [1:0]         s_bresp,
  output logic               s_bvalid,
  input  logic               s_bready,
  input  logic [3:0]         s_arid,
  input  logic [31:0]        s_araddr,
  input  logic [7:0]         s_arlen,
  input  logic [2:0]         s_arsize,
  input  logic [1:0]         s_arburst,
  input  logic               s_arvalid,
  output logic               s_arready,
  output logic [3:0]         s_rid,
  output logic [63:0]        s_rdata,
  output logic [1:0]         s_rresp,
  output logic               s_rlast,
  output logic               s_rvalid,
  input  logic               s_rready,
  output logic               sram_en,
  output logic [7:0]         sram_we,
  output logic [WORD_AW-1:0] sram_addr,
  output logic [63:0]        sram_wdata,
  input  logic [63:0]        sram_rdata
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI = {1'b0, BASE_ADDR} + {1'b0, MEM_BYTES};

  state_t      state_q, state_d;
  logic [3:0]  id_q;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [7:0]  beat_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
  logic [1:0]  err_q;
  logic        last_rd_q;
  logic        grant_rd, grant_wr, win, bad, last_beat;

  function automatic logic in_window(input logic [31:0] a);
    return ({1'b0, a} >= WIN_LO) && ({1'b0, a} < WIN_HI);
  endfunction

  // Unsupported burst encodings and illegal WRAP lengths fall back to INCR.
  function automatic logic is_bad(input logic [1:0] b, input logic [7:0] l);
    return (b == 2'd3) ||
           (b == BURST_WRAP && !(l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15));
  endfunction

  function automatic logic [WORD_AW-1:0] word_addr(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE_ADDR) >> 3;
    return off[WORD_AW-1:0];
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] l,
                                            input logic [2:0] s, input logic [1:0] b);
    logic [31:0] step, mask;
    step = 32'd1 << s;
    mask = (({24'd0, l} + 32'd1) << s) - 32'd1;
    if (b == BURST_FIXED)
      return a;
    else if (b == BURST_WRAP && !is_bad(b, l))
      return (a & ~mask) | ((a + step) & mask);
    else
      return a + step;
  endfunction

  assign grant_rd  = s_arvalid & (~s_awvalid | ~last_rd_q);
  assign grant_wr  = s_awvalid & ~grant_rd;
  assign win       = in_window(addr_q);
  assign bad       = is_bad(burst_q, len_q);
  assign last_beat = (beat_q == len_q);

  always_comb begin
    state_d    = state_q;
    s_arready  = 1'b0;
    s_awready  = 1'b0;
    s_wready   = 1'b0;
    s_bvalid   = 1'b0;
    s_bid      = 4'd0;
    s_bresp    = RESP_OKAY;
    s_rvalid   = 1'b0;
    s_rid      = 4'd0;
    s_rdata    = 64'd0;
    s_rresp    = RESP_OKAY;
    s_rlast    = 1'b0;
    sram_en    = 1'b0;
    sram_we    = 8'd0;
    sram_addr  = '0;
    sram_wdata = 64'd0;
    case (state_q)
      IDLE: begin
        s_arready = grant_rd & ~reset;
        s_awready = grant_wr & ~reset;
        if (grant_rd)      state_d = RD_REQ;
        else if (grant_wr) state_d = WR_DATA;
      end
      RD_REQ: begin
        sram_addr = word_addr(addr_q);
        sram_en   = win;
        state_d   = RD_DATA;
      end
      RD_DATA: begin
        // SRAM holds its output until the next access, so R stays stable under backpressure.
        s_rvalid = 1'b1;
        s_rid    = id_q;
        s_rdata  = sram_rdata;
        s_rresp  = !win ? RESP_DECERR : (bad ? RESP_SLVERR : RESP_OKAY);
        s_rlast  = last_beat;
        if (s_rready) state_d = last_beat ? IDLE : RD_REQ;
      end
      WR_DATA: begin
        s_wready  = 1'b1;
        sram_addr = word_addr(addr_q);
        if (s_wvalid && win) begin
          sram_en    = 1'b1;
          sram_we    = s_wstrb;
          sram_wdata = s_wdata;
        end
        if (s_wvalid && last_beat) state_d = WR_RESP;
      end
      WR_RESP: begin
        s_bvalid = 1'b1;
        s_bid    = id_q;
        s_bresp  = (err_q == RESP_DECERR) ? RESP_DECERR : (bad ? RESP_SLVERR : err_q);
        if (s_bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      last_rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (grant_rd) begin
            id_q <= s_arid; addr_q <= s_araddr; len_q <= s_arlen;
            size_q <= s_arsize; burst_q <= s_arburst;
            beat_q <= 8'd0; err_q <= RESP_OKAY;
          end else if (grant_wr) begin
            id_q <= s_awid; addr_q <= s_awaddr; len_q <= s_awlen;
            size_q <= s_awsize; burst_q <= s_awburst;
            beat_q <= 8'd0; err_q <= RESP_OKAY;
          end
        end
        RD_DATA: begin
          if (s_rready) begin
            if (last_beat) begin
              last_rd_q <= 1'b1;
            end else begin
              addr_q <= next_addr(addr_q, len_q, size_q, burst_q);
              beat_q <= beat_q + 8'd1;
            end
          end
        end
        WR_DATA: begin
          if (s_wvalid) begin
            if (!win)
              err_q <= RESP_DECERR;
            else if ((s_wlast != last_beat) && (err_q != RESP_DECERR))
              err_q <= RESP_SLVERR;
            if (!last_beat) begin
              addr_q <= next_addr(addr_q, len_q, size_q, burst_q);
              beat_q <= beat_q + 8'd1;
            end
          end
        end
        WR_RESP: begin
          if (s_bready) last_rd_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with a behavioural SRAM model.
module tb_axi_sram_slave;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  s_awid, s_arid, s_bid, s_rid;
  logic [31:0] s_awaddr, s_araddr;
  logic [7:0]  s_awlen, s_arlen, s_wstrb;
  logic [2:0]  s_awsize, s_arsize;
  logic [1:0]  s_awburst, s_arburst, s_bresp, s_rresp;
  logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
  logic        s_bvalid, s_bready, s_arvalid, s_arready;
  logic        s_rlast, s_rvalid, s_rready;
  logic [63:0] s_wdata, s_rdata;
  logic        sram_en;
  logic [7:0]  sram_we;
  logic [23:0] sram_addr;
  logic [63:0] sram_wdata, sram_rdata;

  logic [63:0] mem [0:1023];
  logic        pre_en = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [63:0] pre_data = '0;
  int          en_cnt = 0;
  int          tests = 0;
  int          fails = 0;

  always #5 clock = ~clock;

  axi_sram_slave dut (
    .clock(clock), .reset(reset),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
    .s_wready(s_wready), .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
    .s_bready(s_bready), .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arvalid(s_arvalid),
    .s_arready(s_arready), .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always @(posedge clock) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    if (sram_en) begin
      en_cnt <= en_cnt + 1;
      if (sram_we == 8'h00)
        sram_rdata <= mem[sram_addr[9:0]];
      else
        for (int b = 0; b < 8; b++)
          if (sram_we[b]) mem[sram_addr[9:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [63:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int n;
    s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = 3'd3; s_arburst = burst;
    s_arvalid = 1'b1; #1;
    n = 0;
    while (s_arready !== 1'b1 && n < 20) begin tick(); n++; end
    if (n >= 20) begin
      tests++; fails++;
      $display("FAIL ar_timeout arready=%b required 1", s_arready);
    end
    tick();
    s_arvalid = 1'b0;
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int n;
    s_awid = id; s_awaddr = addr; s_awlen = len; s_awsize = 3'd3; s_awburst = burst;
    s_awvalid = 1'b1; #1;
    n = 0;
    while (s_awready !== 1'b1 && n < 20) begin tick(); n++; end
    if (n >= 20) begin
      tests++; fails++;
      $display("FAIL aw_timeout awready=%b required 1", s_awready);
    end
    tick();
    s_awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [63:0] d, input logic [7:0] strb, input logic last);
    int n;
    s_wdata = d; s_wstrb = strb; s_wlast = last; s_wvalid = 1'b1; #1;
    n = 0;
    while (s_wready !== 1'b1 && n < 20) begin tick(); n++; end
    if (n >= 20) begin
      tests++; fails++;
      $display("FAIL w_timeout wready=%b required 1", s_wready);
    end
    tick();
    s_wvalid = 1'b0;
  endtask

  task automatic r_get(output logic [63:0] d, output logic [1:0] resp,
                       output logic last, output logic [3:0] id);
    int n;
    s_rready = 1'b1; #1;
    n = 0;
    while (s_rvalid !== 1'b1 && n < 20) begin tick(); n++; end
    if (n >= 20) begin
      tests++; fails++;
      $display("FAIL r_timeout rvalid=%b required 1", s_rvalid);
    end
    d = s_rdata; resp = s_rresp; last = s_rlast; id = s_rid;
    tick();
    s_rready = 1'b0;
  endtask

  task automatic b_get(output logic [1:0] resp, output logic [3:0] id);
    int n;
    s_bready = 1'b1; #1;
    n = 0;
    while (s_bvalid !== 1'b1 && n < 20) begin tick(); n++; end
    if (n >= 20) begin
      tests++; fails++;
      $display("FAIL b_timeout bvalid=%b required 1", s_bvalid);
    end
    resp = s_bresp; id = s_bid;
    tick();
    s_bready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    tests++;
    if ({s_arready, s_awready, s_wready, s_bvalid, s_rvalid, sram_en} !== 6'b0) begin
      fails++;
      $display("FAIL reset_handshake got=%b required 000000",
               {s_arready, s_awready, s_wready, s_bvalid, s_rvalid, sram_en});
    end
    tests++;
    if ({s_bid, s_rid, s_bresp, s_rresp, s_rlast, sram_we} !== 21'd0 || s_rdata !== 64'd0) begin
      fails++;
      $display("FAIL reset_outputs bid=%h rid=%h bresp=%b rresp=%b rlast=%b we=%h rdata=%h required 0",
               s_bid, s_rid, s_bresp, s_rresp, s_rlast, sram_we, s_rdata);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    logic [63:0] d; logic [1:0] rs; logic l; logic [3:0] id;
    preload(10'd2, 64'h1122334455667788);
    ar_send(4'd5, 32'h8000_0010, 8'd0, 2'd1);
    tests++;
    if (s_rvalid !== 1'b0) begin
      fails++; $display("FAIL read_latency_early rvalid=%b required 0", s_rvalid);
    end
    tick();
    tests++;
    if (s_rvalid !== 1'b1) begin
      fails++; $display("FAIL read_latency rvalid=%b required 1", s_rvalid);
    end
    r_get(d, rs, l, id);
    tests++;
    if (d !== 64'h1122334455667788 || rs !== 2'b00 || l !== 1'b1 || id !== 4'd5) begin
      fails++;
      $display("FAIL single_read data=%h resp=%b last=%b id=%h required 1122334455667788/00/1/5",
               d, rs, l, id);
    end
  endtask

  task automatic test_incr_write_read();
    logic [63:0] d; logic [1:0] rs; logic l; logic [3:0] id;
    aw_send(4'd3, 32'h8000_0100, 8'd3, 2'd1);
    for (int i = 0; i < 4; i++) w_send(64'hA0 + 64'(i), 8'hFF, i == 3);
    b_get(rs, id);
    tests++;
    if (rs !== 2'b00 || id !== 4'd3) begin
      fails++; $display("FAIL incr_write_b resp=%b id=%h required 00/3", rs, id);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (mem[10'h20 + 10'(i)] !== 64'hA0 + 64'(i)) begin
        fails++;
        $display("FAIL incr_write_mem word=%0d got=%h required %h", 32 + i,
                 mem[10'h20 + 10'(i)], 64'hA0 + 64'(i));
      end
    end
    ar_send(4'd2, 32'h8000_0100, 8'd3, 2'd1);
    for (int i = 0; i < 4; i++) begin
      r_get(d, rs, l, id);
      tests++;
      if (d !== 64'hA0 + 64'(i) || rs !== 2'b00 || l !== (i == 3) || id !== 4'd2) begin
        fails++;
        $display("FAIL incr_read beat=%0d data=%h resp=%b last=%b id=%h required %h/00/%0d/2",
                 i, d, rs, l, id, 64'hA0 + 64'(i), (i == 3));
      end
    end
  endtask

  task automatic test_wrap_read();
    logic [63:0] d; logic [1:0] rs; logic l; logic [3:0] id;
    logic [63:0] exp_d [4];
    exp_d[0] = 64'hD3; exp_d[1] = 64'hD0; exp_d[2] = 64'hD1; exp_d[3] = 64'h1122334455667788;
    preload(10'd0, 64'hD0);
    preload(10'd1, 64'hD1);
    preload(10'd3, 64'hD3);
    ar_send(4'd1, 32'h8000_0018, 8'd3, 2'd2);
    for (int i = 0; i < 4; i++) begin
      r_get(d, rs, l, id);
      tests++;
      if (d !== exp_d[i] || rs !== 2'b00 || l !== (i == 3)) begin
        fails++;
        $display("FAIL wrap_read beat=%0d data=%h resp=%b last=%b required %h/00/%0d",
                 i, d, rs, l, exp_d[i], (i == 3));
      end
    end
  endtask

  task automatic test_strobe();
    logic [63:0] d; logic [1:0] rs; logic l; logic [3:0] id;
    preload(10'h40, 64'h0);
    aw_send(4'd0, 32'h8000_0200, 8'd0, 2'd1);
    w_send(64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b1);
    b_get(rs, id);
    ar_send(4'd0, 32'h8000_0200, 8'd0, 2'd1);
    r_get(d, rs, l, id);
    tests++;
    if (d !== 64'h0000_0000_FFFF_FFFF || rs !== 2'b00) begin
      fails++; $display("FAIL strobe_readback data=%h resp=%b required 00000000ffffffff/00", d, rs);
    end
  endtask

  task automatic test_arbitration();
    logic [1:0] rs; logic [3:0] id; int e0; logic stable;
    reset = 1'b1;
    s_arid = 4'd6; s_araddr = 32'h8000_0010; s_arlen = 8'd0; s_arsize = 3'd3; s_arburst = 2'd1;
    s_awid = 4'd7; s_awaddr = 32'h8000_0300; s_awlen = 8'd0; s_awsize = 3'd3; s_awburst = 2'd1;
    s_arvalid = 1'b1; s_awvalid = 1'b1;
    repeat (2) tick();
    tests++;
    if (s_arready !== 1'b0 || s_awready !== 1'b0) begin
      fails++; $display("FAIL arb_in_reset arready=%b awready=%b required 0/0", s_arready, s_awready);
    end
    reset = 1'b0; #1;
    tests++;
    if (s_arready !== 1'b1 || s_awready !== 1'b0) begin
      fails++; $display("FAIL arb_read_first arready=%b awready=%b required 1/0", s_arready, s_awready);
    end
    tick();
    s_arvalid = 1'b0; s_rready = 1'b0;
    tick();
    e0 = en_cnt;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (s_rvalid !== 1'b1 || s_rdata !== 64'h1122334455667788 || s_rlast !== 1'b1 ||
          s_rid !== 4'd6 || en_cnt != e0 || s_awready !== 1'b0) stable = 1'b0;
      tick();
    end
    tests++;
    if (stable !== 1'b1) begin
      fails++;
      $display("FAIL backpressure rvalid=%b rdata=%h rlast=%b en_cnt=%0d required 1/1122334455667788/1/%0d",
               s_rvalid, s_rdata, s_rlast, en_cnt, e0);
    end
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0; #1;
    tests++;
    if (s_awready !== 1'b1) begin
      fails++; $display("FAIL arb_write_second awready=%b required 1", s_awready);
    end
    tick();
    s_awvalid = 1'b0;
    w_send(64'h55, 8'hFF, 1'b1);
    b_get(rs, id);
    tests++;
    if (rs !== 2'b00 || id !== 4'd7 || mem[10'h60] !== 64'h55) begin
      fails++; $display("FAIL arb_write resp=%b id=%h mem=%h required 00/7/55", rs, id, mem[10'h60]);
    end
  endtask

  task automatic test_errors();
    logic [63:0] d; logic [1:0] rs; logic l; logic [3:0] id; int e0;
    e0 = en_cnt;
    ar_send(4'd9, 32'h7FFF_FFF8, 8'd0, 2'd1);
    r_get(d, rs, l, id);
    tests++;
    if (rs !== 2'b11 || l !== 1'b1 || id !== 4'd9 || en_cnt != e0) begin
      fails++;
      $display("FAIL decerr_read resp=%b last=%b id=%h sram_accesses=%0d required 11/1/9/0",
               rs, l, id, en_cnt - e0);
    end
    ar_send(4'd4, 32'h8000_0010, 8'd0, 2'd3);
    r_get(d, rs, l, id);
    tests++;
    if (rs !== 2'b10 || l !== 1'b1) begin
      fails++; $display("FAIL bad_burst_read resp=%b last=%b required 10/1", rs, l);
    end
    aw_send(4'hA, 32'h8000_0400, 8'd1, 2'd1);
    w_send(64'hB0, 8'hFF, 1'b1);
    w_send(64'hB1, 8'hFF, 1'b1);
    b_get(rs, id);
    tests++;
    if (rs !== 2'b10 || id !== 4'hA || mem[10'h80] !== 64'hB0 || mem[10'h81] !== 64'hB1) begin
      fails++;
      $display("FAIL early_wlast resp=%b id=%h w0=%h w1=%h required 10/a/b0/b1",
               rs, id, mem[10'h80], mem[10'h81]);
    end
  endtask

  initial begin
    reset = 1'b1;
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arvalid = 1'b0;
    s_rready = 1'b0;
    test_reset();
    test_single_read();
    test_incr_write_read();
    test_wrap_read();
    test_strobe();
    test_arbitration();
    test_errors();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t required finish before 200000", $time);
    $fatal(1);
  end

endmodule
